inbuf_feed_ctrl: RTL

Sequencer that drains a bank of ROWS row input FIFOs into the systolic PE array with the diagonal skew the array needs. Row r starts reading r cycles after row 0. Every row then pops exactly `len` words, and the array stays enabled for a fixed drain window afterwards. The block sits between the row input FIFOs (their `read`/`empty` pins) and the PE array enable. It stalls the whole wavefront, never a single row, when any row that must supply data is empty.

---
 rtl/systola_ctrl_pkg.sv | 7 +
 rtl/inbuf_feed_ctrl.sv | 78 +++++++
 2 files changed

// File: rtl/systola_ctrl_pkg.sv
// systola_ctrl_pkg: shared state encoding and sizing helper for the input-buffer feed sequencer.
package systola_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} feed_state_t;
  function automatic int step_w(input int lenmax, input int rows);
    return $clog2(lenmax + rows);
  endfunction
endpackage

// File: rtl/inbuf_feed_ctrl.sv
// inbuf_feed_ctrl: drains ROWS row FIFOs into the PE array with diagonal skew, freezing the whole wavefront on any active empty row.
module inbuf_feed_ctrl
  import systola_ctrl_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int LENMAX = 16,
  parameter int DRAIN  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      len,
  input  logic [ROWS-1:0] empty,
  output logic [ROWS-1:0] rd,
  output logic            pe_en,
  output logic            stall,
  output logic            busy,
  output logic            done
);
  localparam int TW = step_w(LENMAX, ROWS);
  localparam int DW = DRAIN > 1 ? $clog2(DRAIN) : 1;
  feed_state_t state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [DW-1:0]   d_q, d_d;
  logic [4:0]      l_q, l_d, len_c;
  logic [ROWS-1:0] act;
  logic            feed, in_drain, last;
  // Row r is live for steps r .. r+L-1, which produces the diagonal skew.
  for (genvar r = 0; r < ROWS; r++) begin : g_act
    assign act[r] = (r <= int'(t_q)) && (int'(t_q) < r + int'(l_q));
  end
  assign len_c    = int'(len) > LENMAX ? 5'(LENMAX) : len;
  assign feed     = state_q == FEED;
  assign in_drain = state_q == systola_ctrl_pkg::DRAIN;
  assign stall    = feed && |(act & empty);
  assign rd       = feed && !stall ? act : '0;
  assign pe_en    = (feed && !stall) || in_drain;
  assign busy     = feed || in_drain;
  assign done     = state_q == DONE;
  assign last     = int'(t_q) == int'(l_q) + ROWS - 2;
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    d_d     = d_q;
    l_d     = l_q;
    case (state_q)
      IDLE: if (start) begin
        l_d     = len_c;
        t_d     = '0;
        state_d = len_c == 5'd0 ? DONE : FEED;
      end
      FEED: if (!stall) begin
        if (last) begin
          d_d     = '0;
          state_d = DRAIN == 0 ? DONE : systola_ctrl_pkg::DRAIN;
        end else t_d = t_q + 1'b1;
      end
      systola_ctrl_pkg::DRAIN: begin
        d_d     = d_q + 1'b1;
        state_d = int'(d_q) == DRAIN - 1 ? DONE : state_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      d_q     <= '0;
      l_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      d_q     <= d_d;
      l_q     <= l_d;
    end
  end
endmodule
